// File: rtl/encrypt_config.sv
// Shared configuration for the encrypt/decrypt cores: bit permutation table,
// default keys and the packet FSM state encoding.
package encrypt_config;

  localparam logic [2:0] PERM_0 = 3'd7;
  localparam logic [2:0] PERM_1 = 3'd6;
  localparam logic [2:0] PERM_2 = 3'd5;
  localparam logic [2:0] PERM_3 = 3'd4;
  localparam logic [2:0] PERM_4 = 3'd3;
  localparam logic [2:0] PERM_5 = 3'd2;
  localparam logic [2:0] PERM_6 = 3'd1;
  localparam logic [2:0] PERM_7 = 3'd0;

  localparam logic [7:0] KEY1 = 8'hDE;
  localparam logic [7:0] KEY2 = 8'hAD;
  localparam logic [7:0] KEY3 = 8'hBE;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } crypt_state_e;

  // Source bit of output bit i.
  function automatic logic [2:0] perm_src(input logic [2:0] i);
    case (i)
      3'd0:    return PERM_0;
      3'd1:    return PERM_1;
      3'd2:    return PERM_2;
      3'd3:    return PERM_3;
      3'd4:    return PERM_4;
      3'd5:    return PERM_5;
      3'd6:    return PERM_6;
      default: return PERM_7;
    endcase
  endfunction

  function automatic logic [7:0] default_key(input logic [1:0] idx);
    case (idx)
      2'd0:    return KEY1;
      2'd1:    return KEY2;
      default: return KEY3;
    endcase
  endfunction

endpackage

// File: rtl/encrypt_core_bit_permute.sv
// Pure combinational byte permutation driven by the shared PERM table.
module bit_permute
  import encrypt_config::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  always_comb begin
    dout = '0;
    for (int i = 0; i < 8; i++) begin
      dout[i] = din[perm_src(3'(i))];
    end
  end

endmodule

// File: rtl/encrypt_core.sv
// Two-stage stream cipher: stage 1 permutes and latches the key for the byte,
// stage 2 XORs. Handshake: a port transfers only when valid && ready are both high.
module encrypt_core
  import encrypt_config::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              cfg_mode,
  input  logic              key_wr,
  input  logic [1:0]        key_sel,
  input  logic [7:0]        key_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              key_err,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  crypt_state_e      state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic              mode_q, mode_d;
  logic              ready_en_q, ready_en_d;
  logic              s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d, s1_key_q, s1_key_d;
  logic              s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
  logic [DATA_W-1:0] s2_data_q, s2_data_d;
  logic [7:0]        key_q [3];
  logic [7:0]        key_d [3];
  logic              key_err_q, key_err_d;

  logic [DATA_W-1:0] perm_data;
  logic              s2_adv, accept, eff_mode;
  logic [7:0]        cur_key;

  bit_permute u_perm (
    .din  (in_data),
    .dout (perm_data)
  );

  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    in_ready = ready_en_q && (state_q != ST_DRAIN) && (!s1_valid_q || s2_adv);
    accept   = in_valid && in_ready;
    // The first byte of a packet uses cfg_mode live; later bytes use the latched copy.
    eff_mode = (state_q == ST_IDLE) ? cfg_mode : mode_q;
    case (idx_q)
      2'd0:    cur_key = eff_mode ? key_q[0] : default_key(2'd0);
      2'd1:    cur_key = eff_mode ? key_q[1] : default_key(2'd1);
      default: cur_key = eff_mode ? key_q[2] : default_key(2'd2);
    endcase

    state_d    = state_q;
    idx_d      = idx_q;
    mode_d     = mode_q;
    ready_en_d = 1'b1;
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    s1_data_d  = s1_data_q;
    s1_key_d   = s1_key_q;
    s2_valid_d = s2_valid_q;
    s2_last_d  = s2_last_q;
    s2_data_d  = s2_data_q;
    key_d      = key_q;
    key_err_d  = 1'b0;

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = s1_data_q ^ s1_key_q;
        s2_last_d = s1_last_q;
      end
    end

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_data_d  = perm_data;
      // Key is captured now so a same-cycle key write cannot affect this byte.
      s1_key_d   = cur_key;
      s1_last_d  = in_last;
      idx_d      = (in_last || idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end else if (s1_valid_q && s2_adv) begin
      s1_valid_d = 1'b0;
    end

    if (key_wr && key_sel != 2'd3) begin
      if (state_q == ST_IDLE) begin
        case (key_sel)
          2'd0:    key_d[0] = key_data;
          2'd1:    key_d[1] = key_data;
          default: key_d[2] = key_data;
        endcase
      end else begin
        key_err_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          mode_d  = cfg_mode;
          state_d = in_last ? ST_DRAIN : ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (accept && in_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (s2_valid_q && out_ready && s2_last_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= 2'd0;
      mode_q     <= 1'b0;
      ready_en_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_data_q  <= '0;
      s1_key_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_data_q  <= '0;
      key_q[0]   <= KEY1;
      key_q[1]   <= KEY2;
      key_q[2]   <= KEY3;
      key_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mode_q     <= mode_d;
      ready_en_q <= ready_en_d;
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      s1_data_q  <= s1_data_d;
      s1_key_q   <= s1_key_d;
      s2_valid_q <= s2_valid_d;
      s2_last_q  <= s2_last_d;
      s2_data_q  <= s2_data_d;
      key_q      <= key_d;
      key_err_q  <= key_err_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_last  = s2_valid_q & s2_last_q;
  assign key_err   = key_err_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_encrypt_core.sv
// Self-checking bench for encrypt_core: directed vector tables, stall, key
// error, reset-abort and randomized-backpressure packets.
module tb_encrypt_core;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       cfg_mode = 1'b0;
  logic       key_wr = 1'b0;
  logic [1:0] key_sel = 2'd0;
  logic [7:0] key_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_last;
  logic       key_err;
  logic       busy;
  logic [1:0] dbg_state;

  encrypt_core #(.DATA_W(8)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .cfg_mode  (cfg_mode),
    .key_wr    (key_wr),
    .key_sel   (key_sel),
    .key_data  (key_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .key_err   (key_err),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_pass = 0;
  logic [8:0] exp_q[$];
  int         acc_q[$];
  bit         lat_on = 1'b0;
  bit         rnd_on = 1'b0;
  logic [7:0] m_key [3];
  int         m_idx = 0;

  typedef struct {
    logic       mode;
    logic [7:0] data;
    logic       last;
    logic [7:0] exp;
  } vec_t;
  vec_t vt [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [7:0] bitrev(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

  function automatic logic [7:0] dflt(input int i);
    logic [7:0] k;
    case (i)
      0:       k = 8'hDE;
      1:       k = 8'hAD;
      default: k = 8'hBE;
    endcase
    return k;
  endfunction

  // Model used for stimulus without a hand-computed table entry.
  function automatic logic [7:0] model_exp(input logic [7:0] d, input logic last, input logic mode);
    logic [7:0] r;
    r = bitrev(d) ^ (mode ? m_key[m_idx] : dflt(m_idx));
    m_idx = last ? 0 : (m_idx + 1) % 3;
    return r;
  endfunction

  // ---------------- monitor ----------------
  logic       hold_v = 1'b0;
  logic [8:0] hold_val = 9'h0;
  always @(negedge clk) begin
    logic [8:0] e;
    int a;
    if (!n_rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'({out_last, out_data}), 32'(hold_val));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_out: got 0x%0h, expected no output (t=%0t)", {out_last, out_data}, $time);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("out_byte", 32'({out_last, out_data}), 32'(e));
          if (lat_on) check("latency", 32'(cyc - a), 32'd2);
        end
      end
      hold_v   = out_valid && !out_ready;
      hold_val = {out_last, out_data};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] d, input logic last, input logic mode, input logic [7:0] exp);
    bit ok = 1'b0;
    cfg_mode = mode;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL send_timeout: in_ready stayed 0 for byte 0x%0h", d);
    end else begin
      exp_q.push_back({last, exp});
      acc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic end_stream();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic key_write(input logic [1:0] s, input logic [7:0] d);
    key_sel  = s;
    key_data = d;
    key_wr   = 1'b1;
    @(posedge clk);
    #1;
    key_wr = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d outputs still pending", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_byte(vt[i].data, vt[i].last, vt[i].mode, vt[i].exp);
    end_stream();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vt[0] = '{1'b0, 8'h01, 1'b0, 8'h5E};
    vt[1] = '{1'b0, 8'h01, 1'b0, 8'h2D};
    vt[2] = '{1'b0, 8'h01, 1'b0, 8'h3E};
    vt[3] = '{1'b0, 8'h01, 1'b1, 8'h5E};
    vt[4] = '{1'b0, 8'h0F, 1'b1, 8'h2E};
    vt[5] = '{1'b0, 8'h0F, 1'b1, 8'h2E};
    vt[6] = '{1'b1, 8'hA5, 1'b0, 8'hA5};
    vt[7] = '{1'b1, 8'hA5, 1'b0, 8'h5A};
    vt[8] = '{1'b1, 8'hA5, 1'b1, 8'hAA};
    for (int i = 0; i < 3; i++) m_key[i] = dflt(i);

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h00);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_key_err", 32'(key_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #2 n_rst = 1'b1;
    #1 check("ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 check("ready_after_edge", 32'(in_ready), 32'd1);
    out_ready = 1'b1;

    // Default keys, back-to-back, with latency
    lat_on = 1'b1;
    run_vecs(0, 3);
    wait_idle();
    // idx returns to 0 after a last byte
    run_vecs(4, 4);
    run_vecs(5, 5);
    wait_idle();
    // Loaded keys
    key_write(2'd0, 8'h00);
    key_write(2'd1, 8'hFF);
    key_write(2'd2, 8'h0F);
    m_key[0] = 8'h00; m_key[1] = 8'hFF; m_key[2] = 8'h0F;
    run_vecs(6, 8);
    wait_idle();

    // Key write outside IDLE is rejected
    send_byte(8'hA5, 1'b0, 1'b1, 8'hA5);
    end_stream();
    check("state_active", 32'(dbg_state), 32'd1);
    key_write(2'd0, 8'h55);
    check("key_err_pulse", 32'(key_err), 32'd1);
    @(posedge clk);
    #1 check("key_err_clear", 32'(key_err), 32'd0);
    key_write(2'd3, 8'h55);
    check("key_err_sel3", 32'(key_err), 32'd0);
    send_byte(8'hA5, 1'b1, 1'b1, 8'h5A);
    end_stream();
    wait_idle();
    send_byte(8'hA5, 1'b1, 1'b1, 8'hA5);
    end_stream();
    wait_idle();

    // Key write coinciding with first byte: byte uses old key
    key_sel = 2'd0; key_data = 8'h33; key_wr = 1'b1;
    send_byte(8'hA5, 1'b1, 1'b1, 8'hA5);
    key_wr = 1'b0;
    end_stream();
    check("coincide_no_err", 32'(key_err), 32'd0);
    m_key[0] = 8'h33;
    wait_idle();
    send_byte(8'hA5, 1'b1, 1'b1, 8'h96);
    end_stream();
    wait_idle();

    // Downstream stall for 5 cycles mid-stream
    lat_on = 1'b0;
    m_idx = 0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          logic [7:0] d;
          d = 8'h10 + 8'(i);
          send_byte(d, (i == 5), 1'b0, model_exp(d, (i == 5), 1'b0));
        end
        end_stream();
      end
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          if (k >= 2) begin
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_out_data", 32'(out_data), 32'hD6);
          end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_idle();

    // Reset mid-packet
    out_ready = 1'b0;
    send_byte(8'h01, 1'b0, 1'b1, 8'h00);
    send_byte(8'h02, 1'b0, 1'b1, 8'h00);
    end_stream();
    @(posedge clk);
    #1 check("pre_reset_valid", 32'(out_valid), 32'd1);
    n_rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    acc_q.delete();
    for (int i = 0; i < 3; i++) m_key[i] = dflt(i);
    m_idx = 0;
    repeat (2) @(posedge clk);
    #2 n_rst = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b1;
    lat_on = 1'b1;
    send_byte(8'h01, 1'b0, 1'b1, 8'h5E);
    send_byte(8'h01, 1'b1, 1'b1, 8'h2D);
    end_stream();
    wait_idle();

    // Random packets with random backpressure
    lat_on = 1'b0;
    for (int i = 0; i < 3; i++) begin
      logic [7:0] k;
      k = 8'($urandom_range(0, 255));
      key_write(2'(i), k);
      m_key[i] = k;
    end
    m_idx = 0;
    rnd_on = 1'b1;
    fork
      begin
        for (int p = 0; p < 4; p++) begin
          int len;
          logic mode;
          len  = $urandom_range(1, 5);
          mode = 1'($urandom_range(0, 1));
          for (int b = 0; b < len; b++) begin
            logic [7:0] d;
            d = 8'($urandom_range(0, 255));
            send_byte(d, (b == len - 1), mode, model_exp(d, (b == len - 1), mode));
          end
          end_stream();
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          if (rnd_on) out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/encrypt_core.md
ENCRYPT_CORE -- requirements
Module: encrypt_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data byte width; only 8 is supported.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port n_rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cfg_mode  in  1  0: package default keys; 1: loaded key registers.
REQ-005 SHALL have port key_wr  in  1  key register write strobe.
REQ-006 SHALL have port key_sel  in  2  key index 0..2; value 3 is ignored.
REQ-007 SHALL have port key_data  in  8  key write value.
REQ-008 SHALL have ports in_valid/in_ready/in_data[8]/in_last  in/out/in/in  plaintext stream.
REQ-009 SHALL have ports out_valid/out_ready/out_data[8]/out_last  out/in/out/out  ciphertext stream.
REQ-010 SHALL have port key_err  out  1  one-cycle pulse on a rejected key write.
REQ-011 SHALL have port busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-012 SHALL transfer on a port only in a cycle where valid and ready are both high.
REQ-013 SHALL form stage 1 as permute: p[i] = in_data[PERM_i], with PERM_i = 7-i (bit reversal).
REQ-014 SHALL form stage 2 as out_data = p XOR K[idx], with K = {KEY1, KEY2, KEY3}.
REQ-015 SHALL use default keys 0xDE, 0xAD, 0xBE when cfg_mode=0.
REQ-016 SHALL capture idx at acceptance and carry it through stage 1 with the byte.
REQ-017 SHALL step idx 0->1->2->0 per accepted byte and return it to 0 after an accepted in_last byte.
REQ-018 SHALL use a two-register pipeline: an accepted byte appears on out_data two cycles later when out_ready is held high.
REQ-019 SHALL sustain one byte per cycle when out_ready is held high.
REQ-020 SHALL advance a stage when its register is empty or its downstream stage advances.
REQ-021 SHALL drive in_ready = !s1_valid || s1 advancing, combinationally.
REQ-022 SHALL hold out_data, out_last and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL propagate in_last alongside its byte to out_last.
REQ-024 SHALL implement FSM states IDLE, ACTIVE and DRAIN:
- IDLE->ACTIVE: first byte accepted without in_last.
- IDLE->DRAIN: first byte accepted with in_last.
- ACTIVE->DRAIN: in_last accepted.
- DRAIN->IDLE: the out_last transfer completes.
REQ-025 SHALL drive in_ready=0 in DRAIN.
REQ-026 SHALL sample cfg_mode on the first accepted byte of a packet and hold it until return to IDLE.
REQ-027 SHALL write key register key_sel on key_wr only in IDLE.
REQ-028 SHALL, when key_wr is asserted outside IDLE, ignore the write and pulse key_err for one cycle.
REQ-029 SHALL, when key_wr and a first byte coincide in IDLE, perform the write but not apply it to that byte, which uses the pre-write key value.
REQ-030 SHALL treat key_sel=3 as a no-op with no key_err.

Reset
REQ-031 SHALL, while n_rst=0, immediately force all of the following:
- FSM to IDLE; idx to 0; pipeline valids to 0.
- outputs out_valid=0, out_last=0, out_data=0x00, key_err=0, busy=0, in_ready=0.
REQ-032 SHALL, during reset, load the key registers with 0xDE, 0xAD, 0xBE.
REQ-033 SHALL discard in-flight bytes on reset mid-packet, with no partial output afterwards.
REQ-034 SHALL assert in_ready no earlier than the first clock edge after reset deassertion.

Structure
REQ-035 SHALL take PERM_0..7 and the default keys KEY1..3 from shared package encrypt_config.
REQ-036 SHALL declare the FSM state enum in encrypt_config, for reuse by the decrypt stage.
REQ-037 SHALL place the permutation in one combinational sub-module, bit_permute, reused by the decrypter.

Verification
REQ-038 SHALL cover: cfg_mode=0, bytes 0x01,0x01,0x01,0x01 with out_ready=1 -> outputs 0x5E,0x2D,0x3E,0x5E, first output 2 cycles after acceptance.
REQ-039 SHALL cover: byte 0x0F with in_last, then 0x0F -> 0x2E both times, since idx resets after last.
REQ-040 SHALL cover: cfg_mode=1, keys loaded 0x00,0xFF,0x0F, bytes 0xA5,0xA5,0xA5 -> 0xA5,0x5A,0xAA.
REQ-041 SHALL cover: out_ready=0 for 5 cycles mid-stream -> in_ready=0 after 2 buffered bytes, out_data held stable, no loss or duplication.
REQ-042 SHALL cover: key_wr during ACTIVE -> key_err pulse, keys unchanged (next packet uses old key).
REQ-043 SHALL cover: n_rst asserted mid-packet -> out_valid=0 immediately, next packet starts at idx 0 with default keys.
